// File: rtl/mul_pkg.sv
// Shared types for the multiplier issue controller: op encoding and op decode helpers.
package mul_pkg;

    typedef enum logic [1:0] {
        MUL_W   = 2'd0,
        MULH_W  = 2'd1,
        MULH_WU = 2'd2
    } mul_op_t;

    // Requester index field width inside the shadow pipe (covers up to 4 requesters)
    localparam int unsigned MUL_ID_W = 2;

    // MUL_W low half is sign-agnostic; driving it signed keeps the encoding uniform
    function automatic logic mul_op_is_signed(input mul_op_t op);
        return (op == MUL_W) || (op == MULH_W);
    endfunction

    function automatic logic mul_op_is_high(input mul_op_t op);
        return op != MUL_W;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant starting the search at the pointer; the pointer
// moves past the winner only on cycles where the caller signals that the grant was taken.
module rr_arbiter #(
    parameter int unsigned N = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         req_i,
    input  logic                 advance_i,
    output logic [N-1:0]         grant_o,
    output logic [$clog2(N)-1:0] grant_idx_o
);

    localparam int unsigned PTR_W = $clog2(N);

    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic             found;
    int unsigned      cand;

    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        found       = 1'b0;
        cand        = 0;
        for (int unsigned k = 0; k < N; k++) begin
            cand = (32'(ptr_q) + k) % N;
            if (!found && req_i[cand]) begin
                found         = 1'b1;
                grant_o[cand] = 1'b1;
                grant_idx_o   = PTR_W'(cand);
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (advance_i) begin
            ptr_d = (grant_idx_o == PTR_W'(N - 1)) ? '0 : grant_idx_o + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/mul_issue_ctrl.sv
// Issue/sequencing controller for the 3-stage pipelined multiplier: arbitrates requesters,
// tracks in-flight ops in a shadow valid/tag pipe and returns the selected product half.
module mul_issue_ctrl
    import mul_pkg::*;
#(
    parameter int unsigned N_REQ = 2,
    parameter int unsigned TAG_W = 5
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req_valid_i,
    output logic [N_REQ-1:0]         req_ready_o,
    input  logic [N_REQ*2-1:0]       req_op_i,
    input  logic [N_REQ*32-1:0]      req_a_i,
    input  logic [N_REQ*32-1:0]      req_b_i,
    input  logic [N_REQ*TAG_W-1:0]   req_tag_i,
    input  logic                     flush_i,
    output logic [31:0]              mul_x_o,
    output logic [31:0]              mul_y_o,
    output logic                     mul_signed_o,
    output logic                     mul_stall_o,
    input  logic [63:0]              mul_res_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [31:0]              out_data_o,
    output logic [TAG_W-1:0]         out_tag_o,
    output logic [$clog2(N_REQ)-1:0] out_id_o
);

    localparam int unsigned ID_W = $clog2(N_REQ);

    typedef struct packed {
        logic                v;
        mul_op_t             op;
        logic [TAG_W-1:0]    tag;
        logic [MUL_ID_W-1:0] id;
    } mul_shadow_t;

    mul_shadow_t s2_q, s2_d;
    mul_shadow_t s3_q, s3_d;

    logic             stall;
    logic             accept_en;
    logic [N_REQ-1:0] req_masked;
    logic [N_REQ-1:0] grant;
    logic [ID_W-1:0]  grant_idx;
    logic             accepted;
    mul_op_t          op_sel;
    logic [TAG_W-1:0] tag_sel;

    // Flush overrides backpressure so the multiplier flushes its garbage forward
    assign stall     = s3_q.v & ~out_ready_i & ~flush_i;
    assign accept_en = ~stall & ~flush_i & rst_n;

    assign req_masked = req_valid_i & {N_REQ{accept_en}};
    assign accepted   = |grant;

    rr_arbiter #(
        .N(N_REQ)
    ) u_rr_arbiter (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_i      (req_masked),
        .advance_i  (accepted),
        .grant_o    (grant),
        .grant_idx_o(grant_idx)
    );

    always_comb begin
        op_sel  = mul_op_t'(req_op_i[32'(grant_idx)*2 +: 2]);
        tag_sel = req_tag_i[32'(grant_idx)*TAG_W +: TAG_W];
    end

    always_comb begin
        mul_x_o      = '0;
        mul_y_o      = '0;
        mul_signed_o = 1'b0;
        if (accepted) begin
            mul_x_o      = req_a_i[32'(grant_idx)*32 +: 32];
            mul_y_o      = req_b_i[32'(grant_idx)*32 +: 32];
            mul_signed_o = mul_op_is_signed(op_sel);
        end
    end

    assign req_ready_o = grant;
    assign mul_stall_o = stall;

    always_comb begin
        s2_d = s2_q;
        s3_d = s3_q;
        if (flush_i) begin
            s2_d.v = 1'b0;
            s3_d.v = 1'b0;
        end else if (!stall) begin
            s2_d.v   = accepted;
            s2_d.op  = op_sel;
            s2_d.tag = tag_sel;
            s2_d.id  = MUL_ID_W'(grant_idx);
            s3_d     = s2_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s2_q <= '0;
            s3_q <= '0;
        end else begin
            s2_q <= s2_d;
            s3_q <= s3_d;
        end
    end

    assign out_valid_o = s3_q.v & ~flush_i;
    assign out_data_o  = mul_op_is_high(s3_q.op) ? mul_res_i[63:32] : mul_res_i[31:0];
    assign out_tag_o   = s3_q.tag;
    assign out_id_o    = s3_q.id[ID_W-1:0];

endmodule
